// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Holds the PC and fetches 32-bit words from instruction memory, with at most one
// request outstanding. Returned words go into a small in-order queue, and decode
// drains that queue through a valid/ready handshake. A taken-branch redirect flushes
// the queue and restarts fetch at the new PC. If a request is in flight when the
// redirect arrives, its response is discarded when it comes back.
//
// Ports
//   clk_i, rst_i           clock; synchronous active-high reset
//   imem_req_valid_o       fetch request valid
//   imem_req_ready_i       memory accepts the request this cycle
//   imem_req_addr_o        word-aligned fetch byte address
//   imem_rsp_valid_i       one-cycle response pulse per accepted request
//   imem_rsp_data_i        instruction word
//   dec_valid_o            queue head presented to decode
//   dec_ready_i            decode accepts the head this cycle
//   dec_instr_o            head instruction word (0 when empty)
//   dec_opcode_o           dec_instr_o[31:26]
//   dec_pc_o               byte address of the head instruction (0 when empty)
//   redirect_valid_i       taken branch: flush and refetch
//   redirect_pc_i          new PC; bits [1:0] are forced to 0
//
// state  | meaning
// S_IDLE | no request; wait for queue credit
// S_REQ  | request presented; address held until accepted
// S_WAIT | request accepted; waiting for its response
module instr_fetch_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DEPTH    = 2,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [ADDR_W-1:0] imem_req_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [31:0]       imem_rsp_data_i,
   output logic              dec_valid_o,
   input  logic              dec_ready_i,
   output logic [31:0]       dec_instr_o,
   output logic [5:0]        dec_opcode_o,
   output logic [ADDR_W-1:0] dec_pc_o,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;         // next address to fetch
   logic [ADDR_W-1:0] req_addr_q;   // address of the current request (also its PC)
   logic              req_valid_q;
   logic              req_stale_q;  // redirect seen while the request was unaccepted
   logic              stale_q;      // outstanding response must be discarded

   logic [31:0]       instr_q [DEPTH];
   logic [ADDR_W-1:0] ipc_q   [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q;

   logic [ADDR_W-1:0] redir_pc;
   logic [ADDR_W-1:0] fetch_pc;
   logic              accept, rsp_in, push, pop, not_empty;
   logic              idle_go, wait_room;
   logic [CNT_W:0]    cnt_after_push;

   assign redir_pc  = redirect_pc_i & ~ADDR_W'(3);
   assign fetch_pc  = redirect_valid_i ? redir_pc : pc_q;
   assign not_empty = (count_q != '0);
   assign accept    = (state_q == S_REQ) && imem_req_ready_i;
   assign rsp_in    = (state_q == S_WAIT) && imem_rsp_valid_i;
   // A response arriving in a redirect cycle belongs to the old path: drop it.
   assign push      = rsp_in && !stale_q && !redirect_valid_i;
   assign pop       = dec_valid_o && dec_ready_i;

   // Credit uses the registered count only; a same-cycle pop earns no credit.
   assign idle_go        = (count_q < CNT_W'(DEPTH)) && !stale_q;
   assign cnt_after_push = {1'b0, count_q} + {{CNT_W{1'b0}}, push};
   assign wait_room      = redirect_valid_i || (cnt_after_push < (CNT_W + 1)'(DEPTH));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         req_addr_q  <= '0;
         req_valid_q <= 1'b0;
         req_stale_q <= 1'b0;
         stale_q     <= 1'b0;
      end else begin
         if (redirect_valid_i) pc_q <= redir_pc;
         case (state_q)
            S_IDLE: begin
               if (idle_go) begin
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
                  req_addr_q  <= fetch_pc;
                  pc_q        <= fetch_pc + ADDR_W'(4);
                  req_stale_q <= 1'b0;
               end
            end
            S_REQ: begin
               if (accept) begin
                  state_q     <= S_WAIT;
                  req_valid_q <= 1'b0;
                  stale_q     <= req_stale_q || redirect_valid_i;
                  req_stale_q <= 1'b0;
               end else if (redirect_valid_i) begin
                  req_stale_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid_i) begin
                  stale_q <= 1'b0;
                  if (wait_room) begin
                     state_q     <= S_REQ;
                     req_valid_q <= 1'b1;
                     req_addr_q  <= fetch_pc;
                     pc_q        <= fetch_pc + ADDR_W'(4);
                     req_stale_q <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (redirect_valid_i) begin
                  stale_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_q[wr_ptr_q] <= imem_rsp_data_i;
         ipc_q[wr_ptr_q]   <= req_addr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || redirect_valid_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
   end

   assign imem_req_valid_o = req_valid_q;
   assign imem_req_addr_o  = req_addr_q;
   assign dec_valid_o      = not_empty && !redirect_valid_i;
   assign dec_instr_o      = not_empty ? instr_q[rd_ptr_q] : 32'h0;
   assign dec_pc_o         = not_empty ? ipc_q[rd_ptr_q] : '0;
   assign dec_opcode_o     = dec_instr_o[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (ADDR_W=32, DEPTH=2, RESET_PC=0).
// The memory model answers each accepted request one cycle later with mk(addr),
// unless auto_rsp is cleared, in which case the test drives responses by hand.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        dec_valid, dec_ready;
   logic [31:0] dec_instr;
   logic [5:0]  dec_opcode;
   logic [31:0] dec_pc;
   logic        redir;
   logic [31:0] redir_pc;
   logic        auto_rsp;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .imem_req_valid_o (req_valid),
      .imem_req_ready_i (req_ready),
      .imem_req_addr_o  (req_addr),
      .imem_rsp_valid_i (rsp_valid),
      .imem_rsp_data_i  (rsp_data),
      .dec_valid_o      (dec_valid),
      .dec_ready_i      (dec_ready),
      .dec_instr_o      (dec_instr),
      .dec_opcode_o     (dec_opcode),
      .dec_pc_o         (dec_pc),
      .redirect_valid_i (redir),
      .redirect_pc_i    (redir_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return {a[7:2] ^ 6'h2B, a[25:0] ^ 26'h1A5_5A5};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; the memory model answers the request accepted at this edge.
   task automatic tick();
      logic        fire;
      logic [31:0] a;
      fire = req_valid && req_ready;
      a    = req_addr;
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
      if (fire && auto_rsp) begin
         rsp_valid = 1'b1;
         rsp_data  = mk(a);
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redir = 1'b0; redir_pc = 32'h0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_req_valid"}, {31'h0, req_valid}, 32'h0);
      check_eq({tag, "_req_addr"},  req_addr, 32'h0);
      check_eq({tag, "_dec_valid"}, {31'h0, dec_valid}, 32'h0);
      check_eq({tag, "_dec_instr"}, dec_instr, 32'h0);
      check_eq({tag, "_dec_op"},    {26'h0, dec_opcode}, 32'h0);
      check_eq({tag, "_dec_pc"},    dec_pc, 32'h0);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      logic [31:0] w;
      w = mk(pc);
      check_eq({tag, "_valid"}, {31'h0, dec_valid}, 32'h1);
      check_eq({tag, "_pc"},    dec_pc, pc);
      check_eq({tag, "_instr"}, dec_instr, w);
      check_eq({tag, "_op"},    {26'h0, dec_opcode}, {26'h0, w[31:26]});
   endtask

   initial begin
      rst = 1'b1; req_ready = 1'b1; dec_ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
      rsp_valid = 1'b0; rsp_data = 32'h0; auto_rsp = 1'b1;

      // 1: streaming fetch, pc 0,4,8,12, one word every two cycles
      do_reset();
      check_all_zero("t1_reset");
      tick();
      check_eq("t1_req_valid", {31'h0, req_valid}, 32'h1);
      check_eq("t1_req_addr", req_addr, 32'h0);
      check_eq("t1_dv_c1", {31'h0, dec_valid}, 32'h0);
      tick();
      check_eq("t1_dv_c2", {31'h0, dec_valid}, 32'h0);
      tick();
      for (int k = 0; k < 4; k++) begin
         check_head($sformatf("t1_w%0d", k), 32'(4 * k));
         tick();
         check_eq($sformatf("t1_gap%0d", k), {31'h0, dec_valid}, 32'h0);
         tick();
      end

      // 2: decode stalled -> exactly two words queued, fetch stops, then in-order drain
      dec_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 10; k++) tick();
      check_eq("t2_req_idle", {31'h0, req_valid}, 32'h0);
      check_head("t2_h0", 32'h0);
      dec_ready = 1'b1;
      tick();
      check_head("t2_h1", 32'h4);
      tick();
      check_eq("t2_empty", {31'h0, dec_valid}, 32'h0);
      check_eq("t2_req8", {31'h0, req_valid}, 32'h1);
      check_eq("t2_addr8", req_addr, 32'h8);
      tick(); tick();
      check_head("t2_h2", 32'h8);

      // 3: memory not ready for 5 cycles, address held, accepted on the 6th
      req_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq($sformatf("t3_valid%0d", k), {31'h0, req_valid}, 32'h1);
         check_eq($sformatf("t3_addr%0d", k), req_addr, 32'h0);
      end
      req_ready = 1'b1;
      tick();
      check_eq("t3_accepted", {31'h0, req_valid}, 32'h0);
      tick();
      check_head("t3_h0", 32'h0);

      // 4: redirect while a response is outstanding; the late word is dropped
      dec_ready = 1'b0;
      do_reset();
      tick(); tick(); tick();
      check_head("t4_pre", 32'h0);
      auto_rsp = 1'b0;
      tick();
      redir = 1'b1; redir_pc = 32'h0000_0107;
      #1;
      check_eq("t4_dv_redir", {31'h0, dec_valid}, 32'h0);
      tick();
      redir = 1'b0;
      #1;
      check_eq("t4_flushed", {31'h0, dec_valid}, 32'h0);
      check_eq("t4_no_req", {31'h0, req_valid}, 32'h0);
      tick();
      check_eq("t4_still_wait", {31'h0, req_valid}, 32'h0);
      rsp_valid = 1'b1; rsp_data = mk(32'h4);
      tick();
      check_eq("t4_dropped", {31'h0, dec_valid}, 32'h0);
      check_eq("t4_req_valid", {31'h0, req_valid}, 32'h1);
      check_eq("t4_req_addr", req_addr, 32'h104);
      auto_rsp = 1'b1; dec_ready = 1'b1;
      tick(); tick();
      check_head("t4_new", 32'h104);

      // 5: redirect together with a response and a ready decode
      dec_ready = 1'b0;
      do_reset();
      tick(); tick(); tick(); tick();
      check_eq("t5_rsp_present", {31'h0, rsp_valid}, 32'h1);
      redir = 1'b1; redir_pc = 32'h104; dec_ready = 1'b1;
      #1;
      check_eq("t5_dv_redir", {31'h0, dec_valid}, 32'h0);
      tick();
      redir = 1'b0;
      #1;
      check_eq("t5_empty", {31'h0, dec_valid}, 32'h0);
      check_eq("t5_req_valid", {31'h0, req_valid}, 32'h1);
      check_eq("t5_req_addr", req_addr, 32'h104);
      tick(); tick();
      check_head("t5_new", 32'h104);

      // 6: reset while waiting on a response; the late response is ignored
      do_reset();
      auto_rsp = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
      check_all_zero("t6_reset");
      tick();
      auto_rsp = 1'b1;
      check_eq("t6_no_push", {31'h0, dec_valid}, 32'h0);
      check_eq("t6_req_valid", {31'h0, req_valid}, 32'h1);
      check_eq("t6_req_addr", req_addr, 32'h0);
      tick(); tick();
      check_head("t6_h0", 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
